// File: rtl/ask2_modulator.sv
// 2ASK modulator: gates a ROM carrier by a serial bit stream.
// Optional ASK2_UNDERRUN_CNT_EN adds a saturating underrun counter.
module ask2_modulator #(
  parameter int          CYC_PER_BIT = 4,
  parameter logic [15:0] ZERO_LEVEL  = 16'h8000
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [3:0]  addra,
  input  logic [15:0] douta,
  output logic [15:0] mod_out,
  output logic        mod_valid,
  output logic        sym_start
`ifdef ASK2_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  underrun_cnt
`endif
);

  localparam int N  = 16 * CYC_PER_BIT;
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] SLAST = SW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic vld;
    logic dat;
    logic first;
  } tag_t;

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] s;
  logic [SW-1:0] s_n;
  logic [3:0]    addra_n;
  logic          cur_bit;
  logic          cur_bit_n;
  logic          drn;
  logic          drn_n;
  logic          last;
  logic          rdy;
  tag_t          tag0;
  tag_t          tag0_n;
  tag_t          tag1;

  assign last      = (s == SLAST);
  // Ready is held low while reset is asserted.
  assign bit_ready = rdy & rst_n;

  // Sequencer: phase/sample counters and the tag of the issued address.
  always_comb begin
    state_n   = state;
    s_n       = s;
    addra_n   = addra;
    cur_bit_n = cur_bit;
    drn_n     = drn;
    tag0_n    = '0;
    rdy       = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bit_valid) begin
          state_n   = RUN;
          cur_bit_n = bit_in;
          s_n       = '0;
          addra_n   = 4'd0;
          tag0_n    = {1'b1, bit_in, 1'b1};
        end
      end
      RUN: begin
        rdy     = last;
        addra_n = addra + 4'd1;
        s_n     = s + 1'b1;
        tag0_n  = {1'b1, cur_bit, 1'b0};
        if (last) begin
          if (bit_valid) begin
            cur_bit_n = bit_in;
            s_n       = '0;
            tag0_n    = {1'b1, bit_in, 1'b1};
          end else begin
            state_n = DRAIN;
            addra_n = 4'd0;
            s_n     = '0;
            drn_n   = 1'b0;
            tag0_n  = '0;
          end
        end
      end
      DRAIN: begin
        if (drn) begin
          state_n = IDLE;
        end else begin
          drn_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and issue-stage registers.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s       <= '0;
      addra   <= 4'd0;
      cur_bit <= 1'b0;
      drn     <= 1'b0;
      tag0    <= '0;
    end else begin
      state   <= state_n;
      s       <= s_n;
      addra   <= addra_n;
      cur_bit <= cur_bit_n;
      drn     <= drn_n;
      tag0    <= tag0_n;
    end
  end

  // Tag delay through ROM latency, then the gated output register.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      tag1      <= '0;
      mod_out   <= ZERO_LEVEL;
      mod_valid <= 1'b0;
      sym_start <= 1'b0;
    end else begin
      tag1      <= tag0;
      mod_valid <= tag1.vld;
      sym_start <= tag1.vld & tag1.first;
      mod_out   <= (tag1.vld & tag1.dat) ? douta : ZERO_LEVEL;
    end
  end

`ifdef ASK2_UNDERRUN_CNT_EN
  logic under;

  assign under = (state == RUN) && last && !bit_valid;

  // Count RUN->DRAIN transitions, saturating at 255.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= 8'd0;
    end else if (under && underrun_cnt != 8'hFF) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ask2_modulator.sv
// Directed self-checking bench for ask2_modulator.
// ROM model: 1-cycle latency, ROM[i] = i*16'h1000 + 16'h0800.
`timescale 1ns/1ps
module tb_ask2_modulator;

  logic        clka;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [3:0]  addra;
  logic [15:0] douta;
  logic [15:0] mod_out;
  logic        mod_valid;
  logic        sym_start;
`ifdef ASK2_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ask2_modulator #(
    .CYC_PER_BIT(4),
    .ZERO_LEVEL (16'h8000)
  ) dut (
    .clka     (clka),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .addra    (addra),
    .douta    (douta),
    .mod_out  (mod_out),
    .mod_valid(mod_valid),
    .sym_start(sym_start)
`ifdef ASK2_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Carrier ROM with one cycle of read latency.
  always @(posedge clka) douta <= {addra, 12'h800};

  // Drive k bits (bits[0] first) with valid held high and check the samples.
  task automatic run_bits(input logic [7:0] bits, input int k,
                          input string name);
    int idx = 0;
    int first_acc = -1;
    int last_acc = -1;
    int first_v = -1;
    int lastv = -1;
    int nsamp = 0;
    int gaps = 0;
    int bad = 0;
    int symbad = 0;
    int nsym = 0;
    int rq[$];
    logic [15:0] exp;
    for (int c = 0; c < k * 64 + 20; c++) begin
      @(negedge clka);
      if (mod_valid) begin
        if (first_v < 0) first_v = c;
        else if (lastv != c - 1) gaps++;
        lastv = c;
        if (nsamp < k * 64) begin
          exp = bits[nsamp / 64] ? 16'((nsamp % 16) * 4096 + 2048) : 16'h8000;
          if (mod_out !== exp) begin
            if (bad == 0)
              $display("FAIL %s sample %0d: got %h want %h",
                       name, nsamp, mod_out, exp);
            bad++;
          end
          if (sym_start !== (nsamp % 64 == 0)) symbad++;
        end
        if (sym_start) nsym++;
        nsamp++;
      end else begin
        if (sym_start !== 1'b0) symbad++;
        if (mod_out !== 16'h8000) bad++;
      end
      bit_valid = (idx < k);
      bit_in = (idx < k) ? bits[idx] : 1'b0;
      if (last_acc >= 0 && c > last_acc && bit_ready) rq.push_back(c - last_acc);
      if (bit_valid && bit_ready) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        rq.delete();
        idx++;
      end
    end
    bit_valid = 1'b0;
    bit_in = 1'b0;
    checks++;
    if (idx !== k) begin
      errors++;
      $display("FAIL %s accepts: got %0d want %0d", name, idx, k);
    end
    checks++;
    if (first_v - first_acc !== 3) begin
      errors++;
      $display("FAIL %s latency: got %0d want 3", name, first_v - first_acc);
    end
    checks++;
    if (nsamp !== k * 64) begin
      errors++;
      $display("FAIL %s nsamp: got %0d want %0d", name, nsamp, k * 64);
    end
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL %s gaps: got %0d want 0", name, gaps);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s data: got %0d bad want 0", name, bad);
    end
    checks++;
    if (symbad !== 0 || nsym !== k) begin
      errors++;
      $display("FAIL %s sym_start: got %0d pulses %0d bad want %0d 0",
               name, nsym, symbad, k);
    end
    checks++;
    if (rq.size() < 2 || rq[0] !== 64 || rq[1] !== 67) begin
      errors++;
      $display("FAIL %s ready_window: got %0d entries first %0d want 64,67",
               name, rq.size(), (rq.size() > 0) ? rq[0] : -1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    repeat (3) @(negedge clka);
    checks++;
    if (bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", bit_ready);
    end
    checks++;
    if (mod_valid !== 1'b0 || sym_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b%b want 00", mod_valid, sym_start);
    end
    checks++;
    if (mod_out !== 16'h8000) begin
      errors++;
      $display("FAIL reset_out: got %h want 8000", mod_out);
    end
    checks++;
    if (addra !== 4'd0) begin
      errors++;
      $display("FAIL reset_addra: got %0d want 0", addra);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b want 1", bit_ready);
    end
  endtask

  task automatic test_single_bit();
    run_bits(8'b1, 1, "single1");
  endtask

  task automatic test_zero_bit();
    run_bits(8'b0, 1, "single0");
  endtask

  task automatic test_back_to_back();
    run_bits(8'b101, 3, "b2b_101");
  endtask

  task automatic test_hold_valid();
    run_bits(8'b01011, 5, "hold_11010");
  endtask

  task automatic test_reset_midbit();
    int n = 0;
    int cyc = 0;
    @(negedge clka);
    bit_valid = 1'b1;
    bit_in = 1'b1;
    @(negedge clka);
    bit_valid = 1'b0;
    while (n < 20 && cyc < 200) begin
      @(negedge clka);
      if (mod_valid) n++;
      cyc++;
    end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL midbit_reach: got %0d want 20", n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mod_valid !== 1'b0 || sym_start !== 1'b0 || bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL midbit_flags: got v%b s%b r%b want 000",
               mod_valid, sym_start, bit_ready);
    end
    checks++;
    if (mod_out !== 16'h8000 || addra !== 4'd0) begin
      errors++;
      $display("FAIL midbit_vals: got %h/%0d want 8000/0", mod_out, addra);
    end
    repeat (2) @(negedge clka);
    rst_n = 1'b1;
    run_bits(8'b1, 1, "after_reset");
  endtask

`ifdef ASK2_UNDERRUN_CNT_EN
  task automatic test_underrun_cnt();
    int w;
    rst_n = 1'b0;
    @(negedge clka);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) run_bits(8'b1, 1, "iso");
    checks++;
    if (underrun_cnt !== 8'd3) begin
      errors++;
      $display("FAIL underrun3: got %0d want 3", underrun_cnt);
    end
    for (int i = 0; i < 297; i++) begin
      w = 0;
      @(negedge clka);
      while (!bit_ready && w < 100) begin
        @(negedge clka);
        w++;
      end
      bit_valid = 1'b1;
      bit_in = 1'b0;
      @(negedge clka);
      bit_valid = 1'b0;
      repeat (68) @(negedge clka);
    end
    checks++;
    if (underrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL underrun_sat: got %0d want 255", underrun_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_bit();
    test_zero_bit();
    test_back_to_back();
    test_hold_valid();
    test_reset_midbit();
`ifdef ASK2_UNDERRUN_CNT_EN
    test_underrun_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
